mem_port_arbiter: RTL and testbench

//  Shares one mem_wrap_fake port between instruction fetch (I) and load/store (D) requesters.

---
 rtl/mem_port_arbiter.sv | 127 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter (fetch I, load/store D) in front of one memory port.
// An owner-tag FIFO records who issued each read so in-order responses are routed back.
module mem_port_arbiter #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MAX_OUTST = 4,
  parameter int D_PRIO    = 0
) (
  input  logic          CLK,
  input  logic          RSTn,
  input  logic          I_REQ,
  input  logic [AW-1:0] I_ADDR,
  output logic          I_RDY,
  output logic [DW-1:0] I_RDATA,
  output logic          I_VALID,
  input  logic          D_REQ,
  input  logic          D_WE,
  input  logic [AW-1:0] D_ADDR,
  input  logic [DW-1:0] D_WDATA,
  output logic          D_RDY,
  output logic [DW-1:0] D_RDATA,
  output logic          D_VALID,
  output logic          PROC_REQ,
  input  logic          MEM_RDY,
  output logic [AW-1:0] ADDR,
  output logic          WE,
  output logic [DW-1:0] WDATA,
  input  logic [DW-1:0] RDATA,
  input  logic          VALID,
  output logic          ERR
);

  // state     | meaning
  // ST_FREE   | no stalled request, grant chosen by priority / round-robin
  // ST_HOLD_I | I request presented but not accepted, grant locked to I
  // ST_HOLD_D | D request presented but not accepted, grant locked to D
  typedef enum logic [1:0] {ST_FREE, ST_HOLD_I, ST_HOLD_D} arb_state_t;

  localparam int PW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int CW = PW + 1;

  arb_state_t           state;
  logic                 rr_ptr;
  logic [MAX_OUTST-1:0] tag_q;
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [CW-1:0]        count;

  logic grant_d;
  logic g_req;
  logic g_read;
  logic empty;
  logic full;
  logic pop;
  logic push;
  logic block;
  logic xfer;
  logic head;

  always_comb begin
    grant_d = 1'b0;
    case (state)
      ST_HOLD_I: grant_d = 1'b0;
      ST_HOLD_D: grant_d = 1'b1;
      default: begin
        if (D_PRIO != 0)  grant_d = D_REQ;
        else if (rr_ptr)  grant_d = D_REQ;
        else              grant_d = ~I_REQ;
      end
    endcase
  end

  assign empty  = (count == '0);
  assign full   = (count == CW'(MAX_OUTST));
  assign pop    = VALID & ~empty;
  assign g_req  = grant_d ? D_REQ : I_REQ;
  assign g_read = ~(grant_d & D_WE);
  // a full FIFO still accepts a read when a response frees a slot this cycle
  assign block  = g_read & full & ~pop;

  assign PROC_REQ = RSTn & g_req & ~block;
  assign xfer     = PROC_REQ & MEM_RDY;
  assign push     = xfer & g_read;
  assign I_RDY    = xfer & ~grant_d;
  assign D_RDY    = xfer & grant_d;

  assign ADDR  = grant_d ? D_ADDR : I_ADDR;
  assign WE    = grant_d & D_WE;
  assign WDATA = D_WDATA;

  assign head    = tag_q[rd_ptr];
  assign I_RDATA = RDATA;
  assign D_RDATA = RDATA;
  assign I_VALID = RSTn & pop & ~head;
  assign D_VALID = RSTn & pop & head;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state  <= ST_FREE;
      rr_ptr <= 1'b0;
    end else if (xfer) begin
      state  <= ST_FREE;
      rr_ptr <= ~grant_d;
    end else if (PROC_REQ) begin
      state  <= grant_d ? ST_HOLD_D : ST_HOLD_I;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      tag_q  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ERR    <= 1'b0;
    end else begin
      if (push) begin
        tag_q[wr_ptr] <= grant_d;
        wr_ptr        <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
      if (VALID && empty) ERR <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized checks of mem_port_arbiter against a transaction-level model.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          CLK = 1'b0;
  logic          RSTn;
  logic          I_REQ, D_REQ, D_WE, MEM_RDY, VALID;
  logic [AW-1:0] I_ADDR, D_ADDR;
  logic [DW-1:0] D_WDATA, RDATA;

  logic          I_RDY, I_VALID, D_RDY, D_VALID, PROC_REQ, WE, ERR;
  logic [DW-1:0] I_RDATA, D_RDATA, WDATA;
  logic [AW-1:0] ADDR;

  logic          p1_I_RDY, p1_I_VALID, p1_D_RDY, p1_D_VALID, p1_PROC_REQ, p1_WE, p1_ERR;
  logic [DW-1:0] p1_I_RDATA, p1_D_RDATA, p1_WDATA;
  logic [AW-1:0] p1_ADDR;

  always #5 CLK = ~CLK;

  mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_OUTST(4), .D_PRIO(0)) dut (
    .CLK(CLK), .RSTn(RSTn),
    .I_REQ(I_REQ), .I_ADDR(I_ADDR), .I_RDY(I_RDY), .I_RDATA(I_RDATA), .I_VALID(I_VALID),
    .D_REQ(D_REQ), .D_WE(D_WE), .D_ADDR(D_ADDR), .D_WDATA(D_WDATA),
    .D_RDY(D_RDY), .D_RDATA(D_RDATA), .D_VALID(D_VALID),
    .PROC_REQ(PROC_REQ), .MEM_RDY(MEM_RDY), .ADDR(ADDR), .WE(WE), .WDATA(WDATA),
    .RDATA(RDATA), .VALID(VALID), .ERR(ERR)
  );

  mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_OUTST(4), .D_PRIO(1)) dut_p1 (
    .CLK(CLK), .RSTn(RSTn),
    .I_REQ(I_REQ), .I_ADDR(I_ADDR), .I_RDY(p1_I_RDY), .I_RDATA(p1_I_RDATA), .I_VALID(p1_I_VALID),
    .D_REQ(D_REQ), .D_WE(D_WE), .D_ADDR(D_ADDR), .D_WDATA(D_WDATA),
    .D_RDY(p1_D_RDY), .D_RDATA(p1_D_RDATA), .D_VALID(p1_D_VALID),
    .PROC_REQ(p1_PROC_REQ), .MEM_RDY(MEM_RDY), .ADDR(p1_ADDR), .WE(p1_WE), .WDATA(p1_WDATA),
    .RDATA(RDATA), .VALID(VALID), .ERR(p1_ERR)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic        own;
    logic [31:0] addr;
  } rd_t;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    I_REQ = 0; I_ADDR = '0; D_REQ = 0; D_WE = 0; D_ADDR = '0; D_WDATA = '0;
    MEM_RDY = 0; VALID = 0; RDATA = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    RSTn = 0;
    tick();
    RSTn = 1;
    tick();
  endtask

  initial begin : main
    logic [31:0] a3 [4];
    rd_t rd_q[$];
    bit i_pend, d_pend, dwe, stall_v, stall_own, pref, g, rd, ep, ex;
    logic [31:0] ia, da, dw;

    idle_inputs();
    RSTn = 0;
    #1;
    // reset: requests and a stray VALID must not leak through
    I_REQ = 1; MEM_RDY = 1; VALID = 1;
    #2;
    chk("rst_proc_req", PROC_REQ, 0);
    chk("rst_i_rdy", I_RDY, 0);
    chk("rst_d_rdy", D_RDY, 0);
    chk("rst_i_valid", I_VALID, 0);
    chk("rst_err", ERR, 0);
    tick();
    chk("rst_err_held", ERR, 0);
    idle_inputs();
    RSTn = 1;
    tick();

    // I only, three reads at 0,4,8
    I_REQ = 1; MEM_RDY = 1;
    for (int k = 0; k < 3; k++) begin
      I_ADDR = 32'(4 * k);
      #3;
      chk("ionly_i_rdy", I_RDY, 1);
      chk("ionly_d_rdy", D_RDY, 0);
      chk("ionly_addr", ADDR, 32'(4 * k));
      chk("ionly_we", WE, 0);
      tick();
    end
    I_REQ = 0;
    for (int k = 0; k < 3; k++) begin
      VALID = 1; RDATA = mdata(32'(4 * k));
      #3;
      chk("ionly_i_valid", I_VALID, 1);
      chk("ionly_d_valid", D_VALID, 0);
      chk("ionly_rdata", I_RDATA, mdata(32'(4 * k)));
      tick();
    end
    VALID = 0;
    #3;
    chk("ionly_idle_req", PROC_REQ, 0);

    // both requesting, round-robin
    do_reset();
    I_REQ = 1; D_REQ = 1; D_WE = 0; MEM_RDY = 1;
    for (int k = 0; k < 4; k++) begin
      I_ADDR = 32'h100 + 32'(16 * k);
      D_ADDR = 32'h800 + 32'(16 * k);
      a3[k]  = (k % 2 == 0) ? I_ADDR : D_ADDR;
      #3;
      chk("rr_i_rdy", I_RDY, (k % 2 == 0));
      chk("rr_d_rdy", D_RDY, (k % 2 == 1));
      chk("rr_addr", ADDR, a3[k]);
      tick();
    end
    I_REQ = 0; D_REQ = 0;
    for (int k = 0; k < 4; k++) begin
      VALID = 1; RDATA = mdata(a3[k]);
      #3;
      chk("rr_i_valid", I_VALID, (k % 2 == 0));
      chk("rr_d_valid", D_VALID, (k % 2 == 1));
      chk("rr_rdata", (k % 2 == 0) ? I_RDATA : D_RDATA, mdata(a3[k]));
      tick();
    end
    VALID = 0;

    // D fixed priority
    do_reset();
    I_REQ = 1; I_ADDR = 32'h40; D_REQ = 1; D_WE = 1; MEM_RDY = 1;
    for (int k = 0; k < 3; k++) begin
      D_ADDR = 32'h900 + 32'(4 * k); D_WDATA = 32'hD0 + 32'(k);
      #3;
      chk("prio_d_rdy", p1_D_RDY, 1);
      chk("prio_i_rdy", p1_I_RDY, 0);
      chk("prio_wdata", p1_WDATA, 32'hD0 + 32'(k));
      tick();
    end
    D_REQ = 0;
    #3;
    chk("prio_i_after", p1_I_RDY, 1);
    chk("prio_addr_after", p1_ADDR, 32'h40);
    tick();

    // stalled I request keeps the grant even when D arrives
    do_reset();
    I_REQ = 1; I_ADDR = 32'h1234; MEM_RDY = 0;
    for (int k = 0; k < 3; k++) begin
      if (k == 1) begin D_REQ = 1; D_WE = 0; D_ADDR = 32'h5678; end
      #3;
      chk("lock_proc_req", PROC_REQ, 1);
      chk("lock_i_rdy", I_RDY, 0);
      chk("lock_addr", ADDR, 32'h1234);
      chk("lock_p1_addr", p1_ADDR, 32'h1234);
      tick();
    end
    MEM_RDY = 1;
    #3;
    chk("lock_i_rdy_rel", I_RDY, 1);
    chk("lock_p1_i_rdy", p1_I_RDY, 1);
    chk("lock_p1_d_rdy", p1_D_RDY, 0);
    tick();
    I_REQ = 0;
    #3;
    chk("lock_p1_d_next", p1_D_RDY, 1);
    tick();

    // FIFO full behaviour
    do_reset();
    MEM_RDY = 1; I_REQ = 1;
    for (int k = 0; k < 4; k++) begin
      I_ADDR = 32'h200 + 32'(4 * k);
      #3;
      chk("full_fill_rdy", I_RDY, 1);
      tick();
    end
    I_ADDR = 32'h210;
    #3;
    chk("full_block", PROC_REQ, 0);
    chk("full_block_rdy", I_RDY, 0);
    D_REQ = 1; D_WE = 1; D_ADDR = 32'hA00; D_WDATA = 32'hCAFE;
    #1;
    chk("full_wr_rdy", D_RDY, 1);
    chk("full_wr_we", WE, 1);
    chk("full_wr_addr", ADDR, 32'hA00);
    chk("full_wr_data", WDATA, 32'hCAFE);
    tick();
    D_REQ = 0; D_WE = 0;
    #3;
    chk("full_block2", PROC_REQ, 0);
    VALID = 1; RDATA = mdata(32'h200);
    #1;
    chk("full_swap_valid", I_VALID, 1);
    chk("full_swap_rdy", I_RDY, 1);
    tick();
    VALID = 0; I_ADDR = 32'h214;
    #3;
    chk("full_still4", PROC_REQ, 0);
    I_REQ = 0;
    for (int k = 1; k < 5; k++) begin
      VALID = 1; RDATA = mdata(32'h200 + 32'(4 * k));
      #3;
      chk("full_drain_i", I_VALID, 1);
      chk("full_drain_d", D_VALID, 0);
      tick();
    end
    VALID = 0;
    #3;
    chk("full_err_clear", ERR, 0);

    // VALID with nothing in flight
    VALID = 1; RDATA = 32'hDEAD;
    #1;
    chk("err_i_valid", I_VALID, 0);
    chk("err_d_valid", D_VALID, 0);
    chk("err_pre", ERR, 0);
    tick();
    VALID = 0;
    #3;
    chk("err_set", ERR, 1);
    tick();
    chk("err_sticky", ERR, 1);

    // reset mid-burst
    I_REQ = 1; MEM_RDY = 1;
    for (int k = 0; k < 2; k++) begin
      I_ADDR = 32'h300 + 32'(4 * k);
      tick();
    end
    RSTn = 0;
    #1;
    chk("mid_rst_req", PROC_REQ, 0);
    chk("mid_rst_i_rdy", I_RDY, 0);
    chk("mid_rst_d_rdy", D_RDY, 0);
    chk("mid_rst_err", ERR, 0);
    tick();
    RSTn = 1; I_REQ = 0;
    tick();
    VALID = 1; RDATA = mdata(32'h300);
    #3;
    chk("mid_rst_flushed", I_VALID, 0);
    tick();
    VALID = 0;
    chk("mid_rst_err_after", ERR, 1);

    // randomized traffic against a transaction model
    do_reset();
    i_pend = 0; d_pend = 0; dwe = 0; stall_v = 0; stall_own = 0; pref = 0;
    ia = '0; da = '0; dw = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!i_pend && $urandom_range(0, 2) != 0) begin i_pend = 1; ia = $urandom & ~32'h3; end
      if (!d_pend && $urandom_range(0, 2) != 0) begin
        d_pend = 1; da = $urandom & ~32'h3; dw = $urandom; dwe = ($urandom_range(0, 2) == 0);
      end
      I_REQ = i_pend; I_ADDR = ia;
      D_REQ = d_pend; D_ADDR = da; D_WDATA = dw; D_WE = dwe;
      MEM_RDY = ($urandom_range(0, 3) != 0);
      VALID = (rd_q.size() > 0) && ($urandom_range(0, 2) == 0);
      RDATA = VALID ? mdata(rd_q[0].addr) : 32'($urandom);
      if (stall_v)              g = stall_own;
      else if (i_pend && d_pend) g = pref;
      else                      g = d_pend;
      rd = !(g && dwe);
      ep = (g ? d_pend : i_pend) && !(rd && rd_q.size() == 4 && !VALID);
      ex = ep && MEM_RDY;
      #3;
      chk("rnd_proc_req", PROC_REQ, ep);
      chk("rnd_i_rdy", I_RDY, ex && !g);
      chk("rnd_d_rdy", D_RDY, ex && g);
      if (ep) begin
        chk("rnd_addr", ADDR, g ? da : ia);
        chk("rnd_we", WE, g && dwe);
      end
      chk("rnd_i_valid", I_VALID, VALID && !rd_q[0].own);
      chk("rnd_d_valid", D_VALID, VALID && rd_q[0].own);
      if (VALID) chk("rnd_rdata", rd_q[0].own ? D_RDATA : I_RDATA, mdata(rd_q[0].addr));
      tick();
      if (VALID) void'(rd_q.pop_front());
      if (ex) begin
        if (rd) rd_q.push_back('{own: g, addr: (g ? da : ia)});
        pref = !g;
        if (g) d_pend = 0; else i_pend = 0;
      end
      stall_v   = ep && !MEM_RDY;
      stall_own = g;
    end
    chk("rnd_err", ERR, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
